// File: rtl/dmem_lsu.sv
// Load/store unit between a CPU port and a word-wide data memory.
// Handles byte/halfword/word accesses, sub-word stores by read-modify-write, and rejects illegal accesses.
module dmem_lsu #(
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    output logic        req_ready,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_in,
    output logic        mem_memwr,
    input  logic [31:0] mem_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD    = 3'd1,
        ST_RD = 3'd2,
        ST_WR = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] wr_word_q, wr_word_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        illegal_s;

    // Picks the addressed lane out of a little-endian word and extends it.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] sz,
                                                 input logic sx, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   r = {{24{sx & b[7]}}, b};
            2'b01:   r = {{16{sx & h[15]}}, h};
            2'b10:   r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Replaces only the addressed lane of the old word with the store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                                input logic [1:0] sz, input logic [1:0] lane);
        logic [31:0] r;
        r = word;
        case (sz)
            2'b00: r[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (lane[1]) begin
                    r[31:16] = wd[15:0];
                end else begin
                    r[15:0] = wd[15:0];
                end
            end
            2'b10:   r = wd;
            default: r = word;
        endcase
        return r;
    endfunction

    assign illegal_s = (size == 2'b11)
                    || ((size == 2'b01) && addr[0])
                    || ((size == 2'b10) && (addr[1:0] != 2'b00))
                    || ((addr >> ADDR_BITS) != 32'd0);

    // Next-state and capture logic for the access sequencer.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        size_d    = size_q;
        sext_d    = sext_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_word_d = wr_word_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    sext_d  = sext;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (illegal_s) begin
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = RESP;
                    end else if (!we) begin
                        state_d = LD;
                    end else if (size == 2'b10) begin
                        wr_word_d = wdata;
                        state_d   = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LD: begin
                rdata_d = load_extract(mem_out, size_q, sext_q, addr_q[1:0]);
                state_d = RESP;
            end
            ST_RD: begin
                wr_word_d = store_merge(mem_out, wdata_q, size_q, addr_q[1:0]);
                state_d   = ST_WR;
            end
            ST_WR: begin
                rdata_d = 32'd0;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d = (state_d == RESP);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            sext_q    <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            wr_word_q <= 32'd0;
            rdata_q   <= 32'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            size_q    <= size_d;
            sext_q    <= sext_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_word_q <= wr_word_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_raddr = {addr_q[31:2], 2'b00};
    assign mem_waddr = {addr_q[31:2], 2'b00};
    assign mem_in    = wr_word_q;
    // Write strobe comes straight from state flops so it is stable before the falling edge.
    assign mem_memwr = (state_q == ST_WR) && we_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed vector table, multi-cycle corner sequences and randomized
// accesses checked against a byte-array memory model.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n, req, we, sext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        req_ready, done, err, mem_memwr;
    logic [31:0] rdata, mem_raddr, mem_waddr, mem_in, mem_out;

    logic [31:0] dut_mem [64];
    logic [7:0]  ref_mem [256];
    int          n_vec = 0;
    int          n_bad = 0;
    int          wr_count = 0;
    logic [31:0] last_waddr = 32'd0;
    logic [31:0] last_memin = 32'd0;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    dmem_lsu #(.ADDR_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_ready(req_ready), .we(we), .size(size),
        .sext(sext), .addr(addr), .wdata(wdata), .done(done), .err(err), .rdata(rdata),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_in(mem_in), .mem_memwr(mem_memwr),
        .mem_out(mem_out)
    );

    assign mem_out = dut_mem[mem_raddr[7:2]];

    always @(negedge clk) begin
        if (mem_memwr === 1'b1) begin
            dut_mem[mem_waddr[7:2]] = mem_in;
            wr_count   = wr_count + 1;
            last_waddr = mem_waddr;
            last_memin = mem_in;
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        dut_mem[a[7:2]] = w;
        for (int i = 0; i < 4; i++) ref_mem[(a & 32'hFC) + i] = w[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = a & 32'hFC;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic ref_illegal(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (a > 32'd255) return 1'b1;
        if (a % nbytes(sz) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sx, input logic [31:0] a);
        logic [31:0] v;
        int n;
        n = nbytes(sz);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8*i));
        if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < nbytes(sz); i++) ref_mem[a + i] = wd[8*i +: 8];
    endtask

    task automatic do_access(input logic a_we, input logic [1:0] a_sz, input logic a_sx,
                             input logic [31:0] a_addr, input logic [31:0] a_wd, input bit hold_junk,
                             output bit got, output int lat, output logic r_err,
                             output logic [31:0] r_data, output int wr_delta, output bit busy_ready);
        int w0;
        int guard;
        got = 0; lat = 0; r_err = 1'b0; r_data = 32'd0; busy_ready = 0; guard = 0;
        while (req_ready !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        w0 = wr_count;
        req = 1'b1; we = a_we; size = a_sz; sext = a_sx; addr = a_addr; wdata = a_wd;
        @(posedge clk);
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if (hold_junk) begin
                we = 1'b1; size = 2'd2; sext = 1'b0; addr = 32'h80; wdata = 32'h0BAD_F00D;
            end else begin
                req = 1'b0;
            end
            if (done === 1'b1) begin
                got = 1; lat = k; r_err = err; r_data = rdata; req = 1'b0;
            end else if (req_ready === 1'b1) begin
                busy_ready = 1;
            end
        end
        req = 1'b0;
        wr_delta = wr_count - w0;
    endtask

    task automatic run_check(input string name, input logic a_we, input logic [1:0] a_sz,
                             input logic a_sx, input logic [31:0] a_addr, input logic [31:0] a_wd,
                             input logic exp_err, input int exp_lat, input logic [31:0] exp_rd);
        bit got, busy;
        int lat, wrd;
        logic r_err;
        logic [31:0] r_data;
        do_access(a_we, a_sz, a_sx, a_addr, a_wd, 1'b0, got, lat, r_err, r_data, wrd, busy);
        check32({name, " done"}, 32'(got), 32'd1);
        check32({name, " latency"}, 32'(lat), 32'(exp_lat));
        check32({name, " err"}, 32'(r_err), 32'(exp_err));
        check32({name, " rdata"}, r_data, exp_rd);
        check32({name, " writes"}, 32'(wrd), (a_we && !exp_err) ? 32'd1 : 32'd0);
        if (a_we && !exp_err) begin
            ref_store(a_sz, a_addr, a_wd);
            check32({name, " memword"}, dut_mem[a_addr[7:2]], ref_word(a_addr));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit got, busy;
        int lat, wrd, w0;
        logic r_err;
        logic [31:0] r_data, saved, a, wd;
        logic [1:0] sz;
        logic rwe, rsx, ill;

        for (int i = 0; i < 64; i++) set_word(32'(i*4), $urandom);
        set_word(32'h10, 32'h4483_2211);
        set_word(32'h20, 32'hAABB_CCDD);

        // Reset with a request pending: reset must win.
        rst_n = 1'b0; req = 1'b1; we = 1'b1; size = 2'd2; sext = 1'b0; addr = 32'h0; wdata = 32'h1;
        repeat (3) @(negedge clk);
        check32("reset req_ready", 32'(req_ready), 32'd1);
        check32("reset done", 32'(done), 32'd0);
        check32("reset err", 32'(err), 32'd0);
        check32("reset rdata", rdata, 32'd0);
        check32("reset memwr", 32'(mem_memwr), 32'd0);
        check32("reset writes", 32'(wr_count), 32'd0);
        req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Halfword read-modify-write store.
        run_check("hw_store", 1'b1, 2'd1, 1'b0, 32'h22, 32'h5A5A_1234, 1'b0, 3, 32'd0);
        check32("hw_store waddr", last_waddr, 32'h20);
        check32("hw_store mem_in", last_memin, 32'h1234_CCDD);

        tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h12,  32'h0,         1'b0, 2, 32'hFFFF_FF83});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h12,  32'h0,         1'b0, 2, 32'h0000_0083});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h11,  32'h0,         1'b0, 2, 32'h0000_0022});
        tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h12,  32'h0,         1'b0, 2, 32'h0000_4483});
        tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h10,  32'h0,         1'b0, 2, 32'h0000_2211});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,         1'b0, 2, 32'h4483_2211});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h05,  32'h0,         1'b1, 1, 32'h0});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h100, 32'hCAFE_F00D, 1'b1, 1, 32'h0});
        tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h10,  32'h0,         1'b1, 1, 32'h0});
        tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h13,  32'h0,         1'b1, 1, 32'h0});
        tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h21,  32'h1111,      1'b1, 1, 32'h0});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,         1'b0, 2, 32'h0000_0044});
        tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h21,  32'h0000_00AB, 1'b0, 3, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 1'b1, 32'h20,  32'h0,         1'b0, 2, 32'h1234_ABDD});
        tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h22,  32'h0,         1'b0, 2, 32'h0000_1234});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h24,  32'h8765_4321, 1'b0, 2, 32'h0});
        tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h26,  32'h0,         1'b0, 2, 32'hFFFF_8765});
        tbl.push_back('{1'b1, 2'd0, 1'b0, 32'hFF,  32'h0000_009C, 1'b0, 3, 32'h0});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 32'hFF,  32'h0,         1'b0, 2, 32'hFFFF_FF9C});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h100, 32'h0,         1'b1, 1, 32'h0});
        foreach (tbl[i]) begin
            run_check($sformatf("vec%0d", i), tbl[i].we, tbl[i].sz, tbl[i].sx, tbl[i].addr,
                      tbl[i].wd, tbl[i].exp_err, tbl[i].exp_lat, tbl[i].exp_rd);
        end

        // Back-to-back: store with req held high while busy, then an immediate load.
        saved = dut_mem[32];
        do_access(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF, 1'b1, got, lat, r_err, r_data, wrd, busy);
        check32("b2b store done", 32'(got), 32'd1);
        check32("b2b store latency", 32'(lat), 32'd2);
        check32("b2b store writes", 32'(wrd), 32'd1);
        check32("b2b ready while busy", 32'(busy), 32'd0);
        check32("b2b junk ignored", dut_mem[32], saved);
        ref_store(2'd2, 32'h40, 32'hDEAD_BEEF);
        run_check("b2b load", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0, 2, 32'hDEAD_BEEF);

        // Reset while in the read phase of a byte store: nothing may be written.
        @(negedge clk);
        saved = dut_mem[12]; w0 = wr_count;
        req = 1'b1; we = 1'b1; size = 2'd0; sext = 1'b0; addr = 32'h31; wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check32("rst_strd req_ready", 32'(req_ready), 32'd1);
        check32("rst_strd memwr", 32'(mem_memwr), 32'd0);
        check32("rst_strd done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check32("rst_strd writes", 32'(wr_count - w0), 32'd0);
        check32("rst_strd memword", dut_mem[12], saved);

        // Reset sampled during the write cycle: that cycle's write still lands, none after.
        w0 = wr_count;
        req = 1'b1; we = 1'b1; size = 2'd0; sext = 1'b0; addr = 32'h35; wdata = 32'h77;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check32("rst_stwr req_ready", 32'(req_ready), 32'd1);
        check32("rst_stwr memwr", 32'(mem_memwr), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check32("rst_stwr writes", 32'(wr_count - w0), 32'd1);
        ref_store(2'd0, 32'h35, 32'h77);
        check32("rst_stwr memword", dut_mem[13], ref_word(32'h34));

        // Randomized traffic against the byte-array model.
        for (int n = 0; n < 200; n++) begin
            rwe = 1'($urandom_range(0, 1));
            rsx = 1'($urandom_range(0, 1));
            wd  = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: sz = 2'd0;
                4, 5, 6:    sz = 2'd1;
                7, 8:       sz = 2'd2;
                default:    sz = 2'd3;
            endcase
            a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(256, 300)) : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a - (a % nbytes(sz));
            ill = ref_illegal(sz, a);
            run_check($sformatf("rnd%0d", n), rwe, sz, rsx, a, wd, ill,
                      ill ? 1 : (!rwe ? 2 : (sz == 2'd2 ? 2 : 3)),
                      (ill || rwe) ? 32'd0 : ref_load(sz, rsx, a));
        end

        for (int i = 0; i < 64; i++)
            check32($sformatf("final mem[%0d]", i), dut_mem[i], ref_word(32'(i*4)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
